// File: rtl/arb_mux_pkg.sv
// ============================================================================
// Module      : arb_mux_pkg
// Description : Shared defaults, legal channel-count range and width helpers
//               for the arbitrating N:1 word multiplexer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package arb_mux_pkg;

  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_NUM_IN = 4;
  localparam int NUM_IN_MIN     = 2;
  localparam int NUM_IN_MAX     = 16;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

  // Channel index width; a single channel still needs one bit.
  function automatic int sel_width(input int num_in);
    return (clog2(num_in) < 1) ? 1 : clog2(num_in);
  endfunction

endpackage : arb_mux_pkg

`default_nettype wire

// File: rtl/arb_mux_picker.sv
// ============================================================================
// Module      : arb_mux_picker
// Description : Combinational request picker. Searches from ptr upward with
//               wrap at NUM_IN; ptr = 0 gives lowest-index-wins priority.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_mux_picker
  import arb_mux_pkg::*;
#(
  parameter int NUM_IN = DEFAULT_NUM_IN,
  parameter int SEL_W  = sel_width(DEFAULT_NUM_IN)
) (
  input  logic [NUM_IN-1:0] valid,
  input  logic [SEL_W-1:0]  ptr,
  output logic [NUM_IN-1:0] grant,
  output logic [SEL_W-1:0]  idx,
  output logic              any
);

  always_comb begin
    int ch;
    ch    = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      // ptr is always below NUM_IN, so one subtraction is enough to wrap.
      ch = int'(ptr) + k;
      if (ch >= NUM_IN) begin
        ch = ch - NUM_IN;
      end
      if (!any && valid[ch]) begin
        any       = 1'b1;
        grant[ch] = 1'b1;
        idx       = SEL_W'(ch);
      end
    end
  end

endmodule : arb_mux_picker

`default_nettype wire

// File: rtl/arb_mux_nto1.sv
// ============================================================================
// Module      : arb_mux_nto1
// Description : N-input arbitrating word mux with a registered valid/ready
//               output stage. Define MUX_RR_EN for round-robin arbitration;
//               otherwise the lowest valid channel index wins.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_mux_nto1
  import arb_mux_pkg::*;
#(
  parameter  int WIDTH  = DEFAULT_WIDTH,
  parameter  int NUM_IN = DEFAULT_NUM_IN,
  localparam int SEL_W  = sel_width(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready
);

  if ((NUM_IN < NUM_IN_MIN) || (NUM_IN > NUM_IN_MAX)) begin : g_num_in_range_err
    $error("arb_mux_nto1: NUM_IN out of supported range");
  end

  logic [SEL_W-1:0]  ptr;
  logic [NUM_IN-1:0] grant;
  logic [SEL_W-1:0]  grant_idx;
  logic              grant_any;
  logic              load_ok;
  logic              xfer;
  logic [WIDTH-1:0]  sel_word;

  arb_mux_picker #(
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_picker (
    .valid (in_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  assign load_ok = ~out_valid | out_ready;
  assign xfer    = grant_any & load_ok;

  // Gating with reset makes in_ready fall immediately when reset asserts.
  assign in_ready = (load_ok && !reset) ? grant : '0;

  // Grant is one-hot, so an AND-OR reduction is a single N:1 mux level.
  always_comb begin
    sel_word = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant[i]) begin
        sel_word = sel_word | in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= sel_word;
      out_sel   <= grant_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef MUX_RR_EN
  // Wrap explicitly so a non-power-of-two NUM_IN never points past the last channel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (xfer) begin
      if (grant_idx == SEL_W'(NUM_IN - 1)) begin
        ptr <= '0;
      end else begin
        ptr <= grant_idx + 1'b1;
      end
    end
  end
`else
  assign ptr = '0;
`endif

endmodule : arb_mux_nto1

`default_nettype wire

// File: tb/tb_arb_mux_nto1.sv
// ============================================================================
// Module      : tb_arb_mux_nto1
// Description : Scoreboard bench for arb_mux_nto1 (NUM_IN=4 main instance,
//               NUM_IN=3 instance for the non-power-of-two wrap sequence).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_arb_mux_nto1;

  localparam int W = 32;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic [1:0]     out_sel;
  logic           out_valid;
  logic           out_ready;

  logic [3*W-1:0] in_data3;
  logic [2:0]     in_valid3;
  logic [2:0]     in_ready3;
  logic [W-1:0]   out_data3;
  logic [1:0]     out_sel3;
  logic           out_valid3;
  logic           out_ready3;

  always #5 clk = ~clk;

  arb_mux_nto1 #(.WIDTH(W), .NUM_IN(N)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  arb_mux_nto1 #(.WIDTH(W), .NUM_IN(3)) u_dut3 (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data3),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .out_data  (out_data3),
    .out_sel   (out_sel3),
    .out_valid (out_valid3),
    .out_ready (out_ready3)
  );

  typedef struct packed {
    logic [W-1:0] data;
    logic [1:0]   sel;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;

  logic         m_valid = 1'b0;
  int           m_ptr   = 0;
  logic [W-1:0] m_data  = '0;
  logic [1:0]   m_sel   = '0;

  logic [N-1:0] pend   = '0;
  logic [W-1:0] word [N];
  logic [N-1:0] refill = '0;
  bit           rand_arrive = 1'b0;
  bit           rand_ready  = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int p, input int n);
    int c;
    for (int k = 0; k < n; k++) begin
      c = p + k;
      if (c >= n) c = c - n;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic drive();
    in_valid = pend;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = word[i];
  endtask

  // One clock of stimulus, model update and scoreboard comparison.
  task automatic cycle();
    int           g;
    logic         lok;
    logic [N-1:0] er;
    bit           xfer;
    exp_t         e;
    drive();
    @(negedge clk);
    lok = !m_valid || out_ready;
`ifdef MUX_RR_EN
    g = pick(pend, m_ptr, N);
`else
    g = pick(pend, 0, N);
`endif
    er   = '0;
    xfer = 1'b0;
    if (g >= 0 && lok) begin
      er[g] = 1'b1;
      xfer  = 1'b1;
    end
    check_eq("in_ready", 32'(in_ready), 32'(er));
    if (xfer) begin
      sb.push_back('{data: word[g], sel: 2'(g)});
      m_ptr = (g + 1) % N;
    end
    @(posedge clk);
    #1;
    if (xfer) begin
      e       = sb.pop_front();
      m_valid = 1'b1;
      m_data  = e.data;
      m_sel   = e.sel;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    check_eq("out_valid", 32'(out_valid), 32'(m_valid));
    check_eq("out_data", out_data, m_data);
    check_eq("out_sel", 32'(out_sel), 32'(m_sel));
    if (xfer) begin
      pend[g] = refill[g];
      word[g] = $urandom;
    end
    for (int i = 0; i < N; i++) begin
      if (rand_arrive && !pend[i] && !(xfer && i == g)) begin
        pend[i] = ($urandom_range(0, 2) == 0);
        word[i] = $urandom;
      end
    end
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  int rr4  [6];
  int rr3  [4];
  int drop [4];

  initial begin
`ifdef MUX_RR_EN
    rr4  = '{0, 1, 2, 3, 0, 1};
    rr3  = '{0, 1, 2, 0};
`else
    rr4  = '{0, 0, 0, 0, 0, 0};
    rr3  = '{0, 0, 0, 0};
`endif
    for (int i = 0; i < N; i++) word[i] = 32'h1000_0000 + i;
    for (int i = 0; i < 3; i++) in_data3[i*W +: W] = 32'h3000_0000 + i;

    // Reset with every channel requesting: nothing may be granted.
    reset      = 1'b1;
    out_ready  = 1'b1;
    out_ready3 = 1'b1;
    in_valid3  = '0;
    pend       = '1;
    drive();
    #12;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_data", out_data, 32'd0);
    check_eq("rst_out_sel", 32'(out_sel), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("rst_in_ready3", 32'(in_ready3), 32'd0);
    pend = '0;
    drive();
    reset = 1'b0;

    // Three-channel instance: wrap after the last channel.
    in_valid3 = 3'b111;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check_eq("wrap3_valid", 32'(out_valid3), 32'd1);
      check_eq("wrap3_sel", 32'(out_sel3), 32'(rr3[k]));
      check_eq("wrap3_data", out_data3, 32'h3000_0000 + 32'(rr3[k]));
    end

    // Idle after reset.
    repeat (10) cycle();

    // All channels valid continuously.
    pend   = '1;
    refill = '1;
    for (int k = 0; k < 6; k++) begin
      cycle();
      check_eq("seq4_sel", 32'(out_sel), 32'(rr4[k]));
    end
    refill = '0;
    repeat (6) cycle();

    // Single channel.
    pend    = 4'b0100;
    word[2] = 32'hDEAD_BEEF;
    cycle();
    check_eq("single_valid", 32'(out_valid), 32'd1);
    check_eq("single_data", out_data, 32'hDEAD_BEEF);
    check_eq("single_sel", 32'(out_sel), 32'd2);

    // Backpressure while a word is held, then drain and load together.
    out_ready = 1'b0;
    pend      = 4'b0011;
    repeat (5) cycle();
    check_eq("bp_hold_data", out_data, 32'hDEAD_BEEF);
    out_ready = 1'b1;
    cycle();
    check_eq("bp_reload_valid", 32'(out_valid), 32'd1);
    repeat (3) cycle();

    // Channel 0 stops requesting after one more transfer.
    pend   = '1;
    refill = '1;
    repeat (3) cycle();
    refill[0] = 1'b0;
`ifdef MUX_RR_EN
    drop = '{0, 1, 2, 3};
    repeat (1) cycle();
`else
    drop = '{1, 1, 1, 1};
    cycle();
`endif
    for (int k = 0; k < 4; k++) begin
      cycle();
`ifndef MUX_RR_EN
      check_eq("drop0_sel", 32'(out_sel), 32'(drop[k]));
`endif
    end
    refill = '0;
    repeat (6) cycle();

    // Random arrivals and random backpressure.
    rand_arrive = 1'b1;
    rand_ready  = 1'b1;
    repeat (300) cycle();
    rand_arrive = 1'b0;
    rand_ready  = 1'b0;
    out_ready   = 1'b1;
    repeat (8) cycle();

    // Reset in the middle of holding a word.
    pend   = '1;
    refill = '1;
    cycle();
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_eq("async_rst_valid", 32'(out_valid), 32'd0);
    check_eq("async_rst_data", out_data, 32'd0);
    check_eq("async_rst_in_ready", 32'(in_ready), 32'd0);
    #10;
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout got=running exp=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule : tb_arb_mux_nto1

`default_nettype wire
